// File: rtl/seq_matrix_multiplier.sv
// seq_matrix_multiplier: computes C = A x B with one multiply-accumulate unit
// that is shared across every output element. Both operands are taken in a
// single valid/ready transfer. The result is held until the consumer takes it.
// Each element is saturated to OUT_W bits according to the signed/unsigned
// mode captured at acceptance.
module seq_matrix_multiplier #(
   parameter int A_ROWS = 2,
   parameter int A_COLS = 2,
   parameter int B_COLS = 2,
   parameter int DATA_W = 20,
   parameter int OUT_W  = 40
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             signed_mode,
   input  logic [A_ROWS*A_COLS*DATA_W-1:0]  a_flat,
   input  logic [A_COLS*B_COLS*DATA_W-1:0]  b_flat,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [A_ROWS*B_COLS*OUT_W-1:0]   c_flat,
   output logic                             sat,
   output logic                             busy
);

   // The accumulator is wide enough that a full dot product never wraps,
   // in either signed or unsigned interpretation.
   localparam int ACC_W = 2*DATA_W + $clog2(A_COLS) + 1;
   // The clamp compares in a signed domain wider than both the accumulator and
   // the output, so an unsigned sum never looks negative.
   localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
   localparam int R_W   = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
   localparam int K_W   = (A_COLS > 1) ? $clog2(A_COLS) : 1;
   localparam int C_W   = (B_COLS > 1) ? $clog2(B_COLS) : 1;
   localparam int A_NUM = A_ROWS*A_COLS;
   localparam int B_NUM = A_COLS*B_COLS;
   localparam int C_NUM = A_ROWS*B_COLS;

   localparam logic [R_W-1:0] R_LAST = R_W'(A_ROWS-1);
   localparam logic [K_W-1:0] K_LAST = K_W'(A_COLS-1);
   localparam logic [C_W-1:0] C_LAST = C_W'(B_COLS-1);

   localparam logic [EXT_W-1:0]        ONE  = EXT_W'(1);
   localparam logic signed [EXT_W-1:0] S_HI = signed'((ONE << (OUT_W-1)) - ONE);
   localparam logic signed [EXT_W-1:0] S_LO = signed'(~((ONE << (OUT_W-1)) - ONE));
   localparam logic signed [EXT_W-1:0] U_HI = signed'((ONE << OUT_W) - ONE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                    state;
   logic [A_NUM*DATA_W-1:0]   a_reg;
   logic [B_NUM*DATA_W-1:0]   b_reg;
   logic                      mode_reg;
   logic [R_W-1:0]            row;
   logic [C_W-1:0]            col;
   logic [K_W-1:0]            kk;
   logic [ACC_W-1:0]          acc;

   int                        a_idx;
   int                        b_idx;
   int                        c_idx;
   logic [DATA_W-1:0]         a_elem;
   logic [DATA_W-1:0]         b_elem;
   logic [ACC_W-1:0]          a_ext;
   logic [ACC_W-1:0]          b_ext;
   logic [ACC_W-1:0]          prod;
   logic [ACC_W-1:0]          sum;
   logic signed [EXT_W-1:0]   sum_ext;
   logic [OUT_W-1:0]          clamped;
   logic                      clip;

   // Select the current A[row][kk] and B[kk][col] operands and locate the C
   // slot. A compare-per-element mux keeps every slice index constant.
   always_comb begin
      a_idx  = int'(row) * A_COLS + int'(kk);
      b_idx  = int'(kk) * B_COLS + int'(col);
      c_idx  = int'(row) * B_COLS + int'(col);
      a_elem = '0;
      b_elem = '0;
      for (int i = 0; i < A_NUM; i++) begin
         if (i == a_idx) begin
            a_elem = a_reg[i*DATA_W +: DATA_W];
         end
      end
      for (int i = 0; i < B_NUM; i++) begin
         if (i == b_idx) begin
            b_elem = b_reg[i*DATA_W +: DATA_W];
         end
      end
   end

   // The multiply-accumulate step extends both operands to accumulator width.
   // Truncating the product back to ACC_W still gives the exact two's-complement
   // product, because the true magnitude fits in ACC_W bits.
   always_comb begin
      a_ext = mode_reg ? {{(ACC_W-DATA_W){a_elem[DATA_W-1]}}, a_elem}
                       : {{(ACC_W-DATA_W){1'b0}}, a_elem};
      b_ext = mode_reg ? {{(ACC_W-DATA_W){b_elem[DATA_W-1]}}, b_elem}
                       : {{(ACC_W-DATA_W){1'b0}}, b_elem};
      prod  = a_ext * b_ext;
      sum   = acc + prod;
   end

   // Clamp the finished dot product into the OUT_W range for the active mode
   // and flag whether clamping happened.
   always_comb begin
      sum_ext = mode_reg ? signed'({{(EXT_W-ACC_W){sum[ACC_W-1]}}, sum})
                         : signed'({{(EXT_W-ACC_W){1'b0}}, sum});
      clip    = 1'b0;
      clamped = sum_ext[OUT_W-1:0];
      if (mode_reg) begin
         if (sum_ext > S_HI) begin
            clamped = S_HI[OUT_W-1:0];
            clip    = 1'b1;
         end else if (sum_ext < S_LO) begin
            clamped = S_LO[OUT_W-1:0];
            clip    = 1'b1;
         end
      end else if (sum_ext > U_HI) begin
         clamped = U_HI[OUT_W-1:0];
         clip    = 1'b1;
      end
   end

   // Control FSM, iteration counters, accumulator and all registered outputs.
   // The loop order is k innermost, then column, then row. The edge that
   // finishes the last element moves the FSM to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sat       <= 1'b0;
         c_flat    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         mode_reg  <= 1'b0;
         row       <= '0;
         col       <= '0;
         kk        <= '0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= a_flat;
                  b_reg    <= b_flat;
                  mode_reg <= signed_mode;
                  acc      <= '0;
                  row      <= '0;
                  col      <= '0;
                  kk       <= '0;
                  sat      <= 1'b0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (kk == K_LAST) begin
                  for (int i = 0; i < C_NUM; i++) begin
                     if (i == c_idx) begin
                        c_flat[i*OUT_W +: OUT_W] <= clamped;
                     end
                  end
                  if (clip) begin
                     sat <= 1'b1;
                  end
                  acc <= '0;
                  kk  <= '0;
                  if (col == C_LAST) begin
                     col <= '0;
                     if (row == R_LAST) begin
                        row       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                     end else begin
                        row <= row + R_W'(1);
                     end
                  end else begin
                     col <= col + C_W'(1);
                  end
               end else begin
                  acc <= sum;
                  kk  <= kk + K_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
